// File: rtl/crt_scan_doubler.sv
// Line-doubling scan converter: each 15 kHz input line is stored in one half of a
// ping-pong buffer while the other half is replayed twice at double pixel rate.
module crt_scan_doubler #(
    parameter int unsigned MAX_LEN     = 512,
    parameter int unsigned DEFAULT_LEN = 384,
    parameter int unsigned MIN_LEN     = 16,
    parameter int unsigned HS_LEN      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_pix,
    input  logic       ce_pix2x,
    input  logic [3:0] rgb_in,
    input  logic       hs_in_n,
    input  logic       vs_in_n,
    output logic [3:0] rgb_out,
    output logic       hs_out_n,
    output logic       vs_out_n
);
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam logic [AW-1:0] CntMax  = AW'(MAX_LEN - 1);
    localparam logic [AW-1:0] MinLen  = AW'(MIN_LEN);
    localparam logic [AW-1:0] HsLen   = AW'(HS_LEN);
    localparam logic [AW-1:0] DefLen  = AW'(DEFAULT_LEN);

    logic [3:0] mem [2*MAX_LEN];

    logic          hs_in_q;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] len_q, len_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic          vs_lat_q, vs_lat_d;
    logic          vs_q, vs_d;

    // Read pipeline: stage 1 holds the address and sync, stage 2 the outputs.
    logic [AW:0]   raddr_q;
    logic          blank_q;
    logic          vs_s1_q;
    logic [3:0]    rgb_out_q, rgb_out_d;
    logic          hs_out_q;
    logic          vs_out_q;

    logic          line_start;
    logic          wr_en;
    logic          rd_wrap;

    always_comb begin
        line_start = hs_in_q & ~hs_in_n;
        wr_en      = ce_pix & (wr_cnt_q != CntMax);
        rd_wrap    = ce_pix2x & (rd_cnt_q == len_q - AW'(1));

        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        len_d      = len_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        vs_lat_d   = vs_lat_q;
        vs_d       = vs_q;

        if (line_start) begin
            // Short lines are sync glitches and must not shrink the output line.
            if (wr_cnt_q >= MinLen) begin
                len_d = wr_cnt_q;
            end
            wr_cnt_d = '0;
            wbank_d  = ~wbank_q;
            rd_cnt_d = '0;
            rbank_d  = wbank_q;
            vs_lat_d = vs_in_n;
            vs_d     = vs_lat_q;
        end else begin
            if (wr_en) begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
            if (ce_pix2x) begin
                rd_cnt_d = rd_wrap ? '0 : rd_cnt_q + AW'(1);
            end
            if (rd_wrap) begin
                vs_d = vs_lat_q;
            end
        end

        rgb_out_d = blank_q ? 4'h0 : mem[raddr_q];
    end

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank_q, wr_cnt_q}] <= rgb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Cleared low so a low hs_in_n at reset release is not taken as a line start.
            hs_in_q   <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            len_q     <= DefLen;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b1;
            vs_lat_q  <= 1'b1;
            vs_q      <= 1'b1;
            raddr_q   <= '0;
            blank_q   <= 1'b0;
            vs_s1_q   <= 1'b1;
            rgb_out_q <= 4'h0;
            hs_out_q  <= 1'b1;
            vs_out_q  <= 1'b1;
        end else begin
            hs_in_q   <= hs_in_n;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            len_q     <= len_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            vs_lat_q  <= vs_lat_d;
            vs_q      <= vs_d;
            raddr_q   <= {rbank_q, rd_cnt_q};
            blank_q   <= (rd_cnt_q < HsLen);
            vs_s1_q   <= vs_q;
            rgb_out_q <= rgb_out_d;
            hs_out_q  <= ~blank_q;
            vs_out_q  <= vs_s1_q;
        end
    end

    assign rgb_out  = rgb_out_q;
    assign hs_out_n = hs_out_q;
    assign vs_out_n = vs_out_q;

endmodule
